// File: rtl/dac_serial_rx.sv
// rtl/dac_serial_rx.sv - serial two-channel DAC code receiver
// Captures 9-bit address/data frames framed by DAC_scen and drives two 8-bit output codes.
module dac_serial_rx #(
  parameter logic [7:0] RESET_CODE = 8'h00,
  parameter bit         LDAC_MODE  = 1'b0
) (
  input  logic       clk_4M,
  input  logic       rst_n,
  input  logic       DAC_scen,
  input  logic       din,
  input  logic       ldac_n,
  output logic [7:0] dac_a_q,
  output logic [7:0] dac_b_q,
  output logic       upd_a,
  output logic       upd_b,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [8:0] shift_q;
  logic [7:0] in_a_q;
  logic [7:0] in_b_q;

  logic commit;
  logic frame_ok;
  logic load_a_d;
  logic load_b_d;

  // The first high sample of DAC_scen after a run of low samples closes the frame.
  assign commit   = (state_q == SHIFT) && DAC_scen;
  assign frame_ok = commit && (cnt_q == 4'd9);
  assign load_a_d = frame_ok && !shift_q[8];
  assign load_b_d = frame_ok && shift_q[8];
  assign busy     = (state_q == SHIFT);

  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_HI;
      cnt_q     <= 4'd0;
      shift_q   <= 9'd0;
      in_a_q    <= RESET_CODE;
      in_b_q    <= RESET_CODE;
      dac_a_q   <= RESET_CODE;
      dac_b_q   <= RESET_CODE;
      upd_a     <= 1'b0;
      upd_b     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      upd_a     <= load_a_d;
      upd_b     <= load_b_d;
      frame_err <= commit && !frame_ok;

      case (state_q)
        WAIT_HI: begin
          if (DAC_scen) state_q <= IDLE;
        end
        IDLE: begin
          if (!DAC_scen) begin
            state_q <= SHIFT;
            shift_q <= {8'h00, din};
            cnt_q   <= 4'd1;
          end
        end
        SHIFT: begin
          if (!DAC_scen) begin
            shift_q <= {shift_q[7:0], din};
            if (cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end
        end
        default: state_q <= WAIT_HI;
      endcase

      if (load_a_d) in_a_q <= shift_q[7:0];
      if (load_b_d) in_b_q <= shift_q[7:0];

      // In LDAC mode the output copies the pre-edge input register, so a
      // simultaneous commit only reaches the output on the next strobe.
      if (LDAC_MODE) begin
        if (!ldac_n) begin
          dac_a_q <= in_a_q;
          dac_b_q <= in_b_q;
        end
      end else begin
        if (load_a_d) dac_a_q <= shift_q[7:0];
        if (load_b_d) dac_b_q <= shift_q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_rx.sv
// tb/tb_dac_serial_rx.sv - bench for dac_serial_rx in both load modes
module tb_dac_serial_rx;

  logic       clk_4M = 1'b0;
  logic       rst_n;
  logic       DAC_scen;
  logic       din;
  logic       ldac_n;
  logic [7:0] a0, b0, a1, b1;
  logic       ua0, ub0, fe0, bz0;
  logic       ua1, ub1, fe1, bz1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         ua;
    bit         ub;
    bit         fe;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
  } exp_t;

  exp_t sbq[$];

  logic [7:0] in_a, in_b, o0a, o0b, o1a, o1b;

  always #5 clk_4M = ~clk_4M;

  dac_serial_rx #(.RESET_CODE(8'h00), .LDAC_MODE(1'b0)) dut0 (
    .clk_4M(clk_4M), .rst_n(rst_n), .DAC_scen(DAC_scen), .din(din), .ldac_n(ldac_n),
    .dac_a_q(a0), .dac_b_q(b0), .upd_a(ua0), .upd_b(ub0), .frame_err(fe0), .busy(bz0)
  );

  dac_serial_rx #(.RESET_CODE(8'h00), .LDAC_MODE(1'b1)) dut1 (
    .clk_4M(clk_4M), .rst_n(rst_n), .DAC_scen(DAC_scen), .din(din), .ldac_n(ldac_n),
    .dac_a_q(a1), .dac_b_q(b1), .upd_a(ua1), .upd_b(ub1), .frame_err(fe1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_a = 8'h00; in_b = 8'h00;
    o0a = 8'h00; o0b = 8'h00; o1a = 8'h00; o1b = 8'h00;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_upd_a"}, {7'd0, ua0}, 8'd0);
    chk({tag, "_upd_b"}, {7'd0, ub0}, 8'd0);
    chk({tag, "_ferr"},  {7'd0, fe0}, 8'd0);
  endtask

  // Starts and ends at a falling edge; bits are MSB-first in the low n bits.
  task automatic send_frame(input logic [31:0] bits, input int n, input bit ldac_at_commit);
    exp_t e;
    if (ldac_at_commit) begin
      o1a = in_a;
      o1b = in_b;
    end
    if (n == 9) begin
      if (bits[8]) begin in_b = bits[7:0]; o0b = bits[7:0]; end
      else         begin in_a = bits[7:0]; o0a = bits[7:0]; end
    end
    e.ua = (n == 9) && !bits[8];
    e.ub = (n == 9) && bits[8];
    e.fe = (n != 9);
    e.a0 = o0a; e.b0 = o0b; e.a1 = o1a; e.b1 = o1b;
    sbq.push_back(e);

    for (int i = 0; i < n; i++) begin
      DAC_scen = 1'b0;
      din      = bits[n-1-i];
      @(negedge clk_4M);
      chk("busy_shift", {7'd0, bz0}, 8'd1);
      if (i == 0) chk_quiet("pulse_len");
    end
    DAC_scen = 1'b1;
    ldac_n   = ldac_at_commit ? 1'b0 : 1'b1;
    @(negedge clk_4M);
    ldac_n = 1'b1;
    e = sbq.pop_front();
    chk("upd_a",     {7'd0, ua0}, {7'd0, e.ua});
    chk("upd_b",     {7'd0, ub0}, {7'd0, e.ub});
    chk("frame_err", {7'd0, fe0}, {7'd0, e.fe});
    chk("m1_upd_a",  {7'd0, ua1}, {7'd0, e.ua});
    chk("dac_a_m0",  a0, e.a0);
    chk("dac_b_m0",  b0, e.b0);
    chk("dac_a_m1",  a1, e.a1);
    chk("dac_b_m1",  b1, e.b1);
    chk("busy_idle", {7'd0, bz0}, 8'd0);
  endtask

  task automatic pulse_ldac();
    ldac_n = 1'b0;
    @(negedge clk_4M);
    ldac_n = 1'b1;
    o1a = in_a;
    o1b = in_b;
    chk("ldac_a_m1", a1, o1a);
    chk("ldac_b_m1", b1, o1b);
    chk("ldac_a_m0", a0, o0a);
    chk("ldac_b_m0", b0, o0b);
  endtask

  initial begin
    rst_n = 1'b0; DAC_scen = 1'b1; din = 1'b0; ldac_n = 1'b1;
    model_reset();
    @(negedge clk_4M);
    @(negedge clk_4M);
    chk("rst_a0", a0, 8'h00);
    chk("rst_b0", b0, 8'h00);
    chk("rst_a1", a1, 8'h00);
    chk("rst_busy", {7'd0, bz0}, 8'd0);
    chk_quiet("rst");
    rst_n = 1'b1;
    @(negedge clk_4M);

    send_frame(32'h0A5, 9, 1'b0);
    send_frame(32'h13C, 9, 1'b0);
    send_frame(32'h0FF, 9, 1'b0);

    send_frame(32'h0AB, 8, 1'b0);
    send_frame(32'h2AB, 10, 1'b0);
    send_frame(32'hFFFFF, 20, 1'b0);

    // Reset in the middle of a frame, with DAC_scen still low afterwards.
    for (int i = 0; i < 4; i++) begin
      DAC_scen = 1'b0; din = 1'b1;
      @(negedge clk_4M);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_a0", a0, 8'h00);
    chk("midrst_b0", b0, 8'h00);
    chk("midrst_b1", b1, 8'h00);
    chk("midrst_busy", {7'd0, bz0}, 8'd0);
    @(negedge clk_4M);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = i[0];
      @(negedge clk_4M);
      chk("wait_hi_busy", {7'd0, bz0}, 8'd0);
    end
    DAC_scen = 1'b1;
    @(negedge clk_4M);
    chk_quiet("after_rst");
    chk("after_rst_a0", a0, 8'h00);
    chk("after_rst_b0", b0, 8'h00);

    send_frame(32'h181, 9, 1'b0);
    send_frame(32'h055, 9, 1'b0);
    pulse_ldac();
    send_frame(32'h012, 9, 1'b1);
    pulse_ldac();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
